// File: rtl/cmos_pkg.sv
// Shared definitions for the dual-rail CMOS XOR cell.
package cmos_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_CNT_W = 8;

    // A rail pair is healthy when the complement is the exact inverse of the true rail.
    function automatic logic rail_ok(input logic x, input logic xbar);
        return &(x ^ xbar);
    endfunction

endpackage

// File: rtl/cmos_xor_slice.sv
// One bit of the static CMOS XOR pull-up/pull-down network.
module cmos_xor_slice
    import cmos_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic abar,
    input  logic bbar,
    output logic out
);

    assign out = (a & bbar) | (abar & b);

endmodule

// File: rtl/cmos_xor.sv
// Dual-rail XOR cell: combinational result, registered copy and rail-consistency checker.
module cmos_xor
    import cmos_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] abar,
    input  logic [WIDTH-1:0] bbar,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_q,
    output logic             rail_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] bit_ok;
    logic             mismatch;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        cmos_xor_slice u_slice (
            .a    (a[i]),
            .b    (b[i]),
            .abar (abar[i]),
            .bbar (bbar[i]),
            .out  (out[i])
        );
        assign bit_ok[i] = rail_ok(a[i], abar[i]) & rail_ok(b[i], bbar[i]);
    end

    assign mismatch = ~(&bit_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            rail_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            out_q    <= out;
            rail_err <= mismatch;
            // Saturate rather than wrap so a long fault never reads as healthy.
            if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmos_xor.sv
// Self-checking bench for cmos_xor: a narrow 8-bit-counter instance and a wide 2-bit-counter one.
module tb_cmos_xor;

    typedef struct {
        logic [7:0] oq;
        logic       re;
        logic [7:0] ec;
        string      nm;
    } exp_t;

    typedef struct {
        logic a;
        logic b;
        logic out;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Narrow instance: WIDTH=1, CNT_W=8
    logic       a1 = 1'b0, b1 = 1'b0, ab1 = 1'b1, bb1 = 1'b1, rst1 = 1'b1;
    logic       out1, oq1, re1;
    logic [7:0] ec1;

    // Wide instance: WIDTH=8, CNT_W=2
    logic [7:0] a8 = '0, b8 = '0, ab8 = '1, bb8 = '1;
    logic       rst8 = 1'b1;
    logic [7:0] out8, oq8;
    logic       re8;
    logic [1:0] ec8;

    cmos_xor #(.WIDTH(1), .CNT_W(8)) dut1 (
        .out(out1), .a(a1), .b(b1), .abar(ab1), .bbar(bb1),
        .clk(clk), .rst(rst1), .out_q(oq1), .rail_err(re1), .err_cnt(ec1)
    );

    cmos_xor #(.WIDTH(8), .CNT_W(2)) dut8 (
        .out(out8), .a(a8), .b(b8), .abar(ab8), .bbar(bb8),
        .clk(clk), .rst(rst8), .out_q(oq8), .rail_err(re8), .err_cnt(ec8)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   m1 = 0;
    int   m8 = 0;
    exp_t sb1[$];
    exp_t sb8[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step1(input logic a, input logic b, input logic ab, input logic bb,
                         input logic r, input logic eo, input string nm);
        exp_t e;
        logic mm;
        a1 = a; b1 = b; ab1 = ab; bb1 = bb; rst1 = r;
        #1;
        chk({nm, " out"}, 32'(out1), 32'(eo));
        mm = (ab !== ~a) || (bb !== ~b);
        if (r) begin
            m1 = 0;
            e = '{oq: 8'h00, re: 1'b0, ec: 8'h00, nm: nm};
        end else begin
            if (mm && m1 != 255) m1++;
            e = '{oq: {7'b0, eo}, re: mm, ec: 8'(m1), nm: nm};
        end
        sb1.push_back(e);
        @(posedge clk);
        #1;
        e = sb1.pop_front();
        chk({e.nm, " out_q"}, 32'(oq1), 32'(e.oq));
        chk({e.nm, " rail_err"}, 32'(re1), 32'(e.re));
        chk({e.nm, " err_cnt"}, 32'(ec1), 32'(e.ec));
    endtask

    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ab,
                         input logic [7:0] bb, input logic r, input logic [7:0] eo,
                         input string nm);
        exp_t e;
        logic mm;
        a8 = a; b8 = b; ab8 = ab; bb8 = bb; rst8 = r;
        #1;
        chk({nm, " out"}, 32'(out8), 32'(eo));
        mm = (ab !== ~a) || (bb !== ~b);
        if (r) begin
            m8 = 0;
            e = '{oq: 8'h00, re: 1'b0, ec: 8'h00, nm: nm};
        end else begin
            if (mm && m8 != 3) m8++;
            e = '{oq: eo, re: mm, ec: 8'(m8), nm: nm};
        end
        sb8.push_back(e);
        @(posedge clk);
        #1;
        e = sb8.pop_front();
        chk({e.nm, " out_q"}, 32'(oq8), 32'(e.oq));
        chk({e.nm, " rail_err"}, 32'(re8), 32'(e.re));
        chk({e.nm, " err_cnt"}, 32'(ec8), 32'(e.ec));
    endtask

    vec_t       tt[5];
    logic [1:0] sat_exp[5];

    initial begin
        tt[0] = '{a: 1'b0, b: 1'b0, out: 1'b0};
        tt[1] = '{a: 1'b0, b: 1'b1, out: 1'b1};
        tt[2] = '{a: 1'b1, b: 1'b0, out: 1'b1};
        tt[3] = '{a: 1'b1, b: 1'b1, out: 1'b0};
        tt[4] = '{a: 1'b0, b: 1'b0, out: 1'b0};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state
        step1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "reset1");

        // Truth table with consistent rails
        for (int i = 0; i < 5; i++) begin
            step1(tt[i].a, tt[i].b, ~tt[i].a, ~tt[i].b, 1'b0, tt[i].out,
                  $sformatf("tt%0d", i));
        end

        // Registered path on consecutive cycles
        step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "reg_10");
        step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reg_11");

        // Single-cycle rail fault, then recovery
        step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "fault");
        step1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "recover");
        chk("recover err_cnt held", 32'(ec1), 32'd1);

        // Saturation with a 2-bit counter
        step8(8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h00, "reset8");
        for (int i = 0; i < 5; i++) begin
            step8(8'h01, 8'h00, 8'h01, 8'hFF, 1'b0, 8'h01, $sformatf("sat%0d", i));
            chk($sformatf("sat%0d seq", i), 32'(ec8), 32'(sat_exp[i]));
        end

        // Reset priority over a live mismatch at err_cnt=2
        step8(8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h00, "reset8b");
        step8(8'h01, 8'h00, 8'h01, 8'hFF, 1'b0, 8'h01, "pre1");
        step8(8'h01, 8'h00, 8'h01, 8'hFF, 1'b0, 8'h01, "pre2");
        chk("pre2 err_cnt", 32'(ec8), 32'd2);
        step8(8'h01, 8'h00, 8'h01, 8'hFF, 1'b1, 8'h01, "rst_prio");

        // Wide consistent-rail XOR
        step8(8'hA5, 8'h3C, 8'h5A, 8'hC3, 1'b0, 8'h99, "wide");
        chk("wide out_q", 32'(oq8), 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
